// File: rtl/ldpc_3gpp_dec_hb_seq_pkg.sv
// Shared types for the fixed-mode 3GPP LDPC decoder Hb-table sequencer.
//   hb_zc_t        : Zc word address (max lifting size 384)
//   hb_row_t       : row-group index (up to 46 base-graph rows)
//   hb_seq_state_t : sequencer FSM state
package ldpc_3gpp_dec_hb_seq_pkg;

  localparam int cZC_MAX  = 384;
  localparam int cROW_MAX = 46;

  typedef logic [8:0] hb_zc_t;
  typedef logic [5:0] hb_row_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } hb_seq_state_t;

endpackage

// File: rtl/ldpc_3gpp_dec_hb_seq_dly.sv
// Fixed-latency delay line for the {strobe, row, word} read address bundle.
// Turns read issues into write issues pLAT enabled cycles later.
//   iclk/ireset/iclkena : clock, async active-high reset, clock enable
//   istrb/irow/izc      : bundle in
//   ostrb/orow/ozc      : bundle out, pLAT enabled cycles later
//   opend               : a strobe sits in a stage that is not yet the output
module ldpc_3gpp_dec_hb_seq_dly
  import ldpc_3gpp_dec_hb_seq_pkg::*;
#(
  parameter int pLAT = 4
) (
  input  logic    iclk,
  input  logic    ireset,
  input  logic    iclkena,
  input  logic    istrb,
  input  hb_row_t irow,
  input  hb_zc_t  izc,
  output logic    ostrb,
  output hb_row_t orow,
  output hb_zc_t  ozc,
  output logic    opend
);

  logic [pLAT:1] r_vld;
  hb_row_t       r_row [pLAT:1];
  hb_zc_t        r_zc  [pLAT:1];

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_vld <= '0;
      for (int k = 1; k <= pLAT; k++) begin
        r_row[k] <= '0;
        r_zc[k]  <= '0;
      end
    end else if (iclkena) begin
      for (int k = pLAT; k >= 2; k--) begin
        r_vld[k] <= r_vld[k-1];
        r_row[k] <= r_row[k-1];
        r_zc[k]  <= r_zc[k-1];
      end
      r_vld[1] <= istrb;
      r_row[1] <= irow;
      r_zc[1]  <= izc;
    end
  end

  assign ostrb = r_vld[pLAT];
  assign orow  = r_row[pLAT];
  assign ozc   = r_zc[pLAT];

  // Only the inner stages count: the output stage empties on the next edge,
  // which lets the sequencer leave DRAIN in the same cycle as the last write.
  generate
    if (pLAT > 1) begin : g_pend
      assign opend = |r_vld[pLAT-1:1];
    end else begin : g_nopend
      assign opend = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ldpc_3gpp_dec_hb_seq.sv
// Hb table row/word address sequencer for the fixed-mode 3GPP LDPC decoder.
// Per iteration walks every used row group and, inside each, every Zc word,
// issuing reads at once and the matching writes pWRITE_LAT cycles later.
//   iclk, ireset, iclkena           : clock, async active-high reset, enable
//   istart, iNiter, iused_zc/_row   : start request and run parameters
//   obusy, odone                    : run in progress / one-cycle completion
//   oread, orrow, orzc              : read strobe and address
//   owrite, owrow, owzc             : write strobe and address
//   oiter, olast_iter               : current read iteration / final-iteration flag
module ldpc_3gpp_dec_hb_seq
  import ldpc_3gpp_dec_hb_seq_pkg::*;
#(
  parameter int pROW_BY_CYCLE = 8,
  parameter int pWRITE_LAT    = 4,
  parameter int pITER_W       = 6
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               istart,
  input  logic [pITER_W-1:0] iNiter,
  input  hb_zc_t             iused_zc,
  input  hb_row_t            iused_row,
  output logic               obusy,
  output logic               oread,
  output hb_row_t            orrow,
  output hb_zc_t             orzc,
  output logic               owrite,
  output hb_row_t            owrow,
  output hb_zc_t             owzc,
  output logic [pITER_W-1:0] oiter,
  output logic               olast_iter,
  output logic               odone
);

  localparam logic [pITER_W-1:0] cITER_ONE = pITER_W'(1);

  generate
    if (pWRITE_LAT < 1 ||
        ((cROW_MAX + pROW_BY_CYCLE - 1) / pROW_BY_CYCLE) > (2**$bits(hb_row_t) - 1) ||
        cZC_MAX > (2**$bits(hb_zc_t) - 1)) begin : g_param_err
      $error("ldpc_3gpp_dec_hb_seq: unsupported parameter set");
    end
  endgenerate

  hb_seq_state_t      r_state;
  logic [pITER_W-1:0] r_niter, r_iter;
  hb_zc_t             r_used_zc, r_zc;
  hb_row_t            r_used_row, r_row;

  logic               w_read, w_pend;
  logic               w_zc_last, w_row_last, w_iter_last;
  hb_zc_t             w_zc_m1;
  hb_row_t            w_row_m1;
  logic [pITER_W-1:0] w_niter_m1;

  assign w_zc_m1     = r_used_zc - hb_zc_t'(1);
  assign w_row_m1    = r_used_row - hb_row_t'(1);
  assign w_niter_m1  = r_niter - cITER_ONE;
  assign w_zc_last   = (r_zc == w_zc_m1);
  assign w_row_last  = (r_row == w_row_m1);
  assign w_iter_last = (r_iter == w_niter_m1);
  assign w_read      = (r_state == ST_RUN);

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_state    <= ST_IDLE;
      r_niter    <= '0;
      r_used_zc  <= '0;
      r_used_row <= '0;
      r_iter     <= '0;
      r_zc       <= '0;
      r_row      <= '0;
    end else if (iclkena) begin
      case (r_state)
        ST_IDLE: if (istart) begin
          r_niter    <= (iNiter == '0) ? cITER_ONE : iNiter;
          r_used_zc  <= iused_zc;
          r_used_row <= iused_row;
          r_iter     <= '0;
          r_zc       <= '0;
          r_row      <= '0;
          // Empty run: nothing is issued; DRAIN sees an empty delay line
          // and finishes on the following edge.
          r_state    <= (iused_zc == '0 || iused_row == '0) ? ST_DRAIN : ST_RUN;
        end
        ST_RUN: begin
          if (!w_zc_last) begin
            r_zc <= r_zc + hb_zc_t'(1);
          end else begin
            r_zc <= '0;
            if (!w_row_last) begin
              r_row <= r_row + hb_row_t'(1);
            end else begin
              r_row <= '0;
              if (!w_iter_last) begin
                r_iter <= r_iter + cITER_ONE;
              end else begin
                r_iter  <= '0;
                r_state <= ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: if (!w_pend) r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  ldpc_3gpp_dec_hb_seq_dly #(
    .pLAT (pWRITE_LAT)
  ) u_dly (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .istrb   (w_read),
    .irow    (r_row),
    .izc     (r_zc),
    .ostrb   (owrite),
    .orow    (owrow),
    .ozc     (owzc),
    .opend   (w_pend)
  );

  assign oread      = w_read;
  assign orrow      = r_row;
  assign orzc       = r_zc;
  assign oiter      = r_iter;
  assign olast_iter = w_read & w_iter_last;
  assign obusy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign odone      = (r_state == ST_DONE);

endmodule

// File: tb/tb_ldpc_3gpp_dec_hb_seq.sv
module tb_ldpc_3gpp_dec_hb_seq;
  import ldpc_3gpp_dec_hb_seq_pkg::*;

  localparam int LAT = 4;
  localparam int IW  = 6;

  logic          iclk = 1'b0;
  logic          ireset, iclkena, istart;
  logic [IW-1:0] iNiter;
  hb_zc_t        iused_zc;
  hb_row_t       iused_row;
  logic          obusy, oread, owrite, olast_iter, odone;
  hb_row_t       orrow, owrow;
  hb_zc_t        orzc, owzc;
  logic [IW-1:0] oiter;

  always #5 iclk = ~iclk;

  ldpc_3gpp_dec_hb_seq #(.pROW_BY_CYCLE(8), .pWRITE_LAT(LAT), .pITER_W(IW)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart),
    .iNiter(iNiter), .iused_zc(iused_zc), .iused_row(iused_row),
    .obusy(obusy), .oread(oread), .orrow(orrow), .orzc(orzc),
    .owrite(owrite), .owrow(owrow), .owzc(owzc),
    .oiter(oiter), .olast_iter(olast_iter), .odone(odone)
  );

  typedef struct packed {
    logic          busy;
    logic          read;
    hb_row_t       rrow;
    hb_zc_t        rzc;
    logic [IW-1:0] iter;
    logic          last;
    logic          write;
    hb_row_t       wrow;
    hb_zc_t        wzc;
    logic          done;
  } obs_t;

  obs_t dut_o;
  assign dut_o = {obusy, oread, orrow, orzc, oiter, olast_iter, owrite, owrow, owzc, odone};

  typedef struct {
    int nit; int z; int r; int mode;
    int exp_rd; int exp_done;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Expected outputs n enabled edges after istart was accepted: the k-th read
  // (k = n-1) addresses word k%z of row (k/z)%r in iteration k/(z*r); writes
  // replay the same address list LAT cycles later.
  function automatic obs_t model(int n, int nit, int z, int r);
    obs_t e;
    int ne, tot, tdone, k;
    e = '0;
    ne = (nit == 0) ? 1 : nit;
    tot = (z == 0 || r == 0) ? 0 : ne * z * r;
    tdone = (tot == 0) ? 2 : tot + LAT + 1;
    e.busy = (n >= 1 && n < tdone);
    e.done = (n == tdone);
    if (n >= 1 && n <= tot) begin
      k = n - 1;
      e.read = 1'b1;
      e.rzc  = hb_zc_t'(k % z);
      e.rrow = hb_row_t'((k / z) % r);
      e.iter = IW'(k / (z * r));
      e.last = ((k / (z * r)) == ne - 1);
    end
    if (n > LAT && n <= tot + LAT) begin
      k = n - 1 - LAT;
      e.write = 1'b1;
      e.wzc   = hb_zc_t'(k % z);
      e.wrow  = hb_row_t'((k / z) % r);
    end
    return e;
  endfunction

  function automatic obs_t mask(obs_t o, obs_t e);
    if (!e.read)  begin o.rrow = '0; o.rzc = '0; o.iter = '0; end
    if (!e.write) begin o.wrow = '0; o.wzc = '0; end
    return o;
  endfunction

  task automatic chk(input string nm, input obs_t e);
    obs_t a, x;
    a = mask(dut_o, e);
    x = mask(e, e);
    n_cmp++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s t=%0t: got busy%b rd%b r%0d z%0d it%0d l%b wr%b r%0d z%0d dn%b, expected busy%b rd%b r%0d z%0d it%0d l%b wr%b r%0d z%0d dn%b",
               nm, $time, a.busy, a.read, a.rrow, a.rzc, a.iter, a.last, a.write, a.wrow, a.wzc, a.done,
               x.busy, x.read, x.rrow, x.rzc, x.iter, x.last, x.write, x.wrow, x.wzc, x.done);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // mode: 0 enable always high, 1 alternating 1,0, 2 random enable
  task automatic run_seq(input string nm, input int nit, input int z, input int r,
                         input int mode, output int nrd, output int nwr, output int ndone);
    int n, ne, tot, tdone;
    bit ok;
    ne = (nit == 0) ? 1 : nit;
    tot = (z == 0 || r == 0) ? 0 : ne * z * r;
    tdone = (tot == 0) ? 2 : tot + LAT + 1;
    nrd = 0; nwr = 0; ndone = -1; ok = 0;
    @(negedge iclk);
    iNiter = IW'(nit); iused_zc = hb_zc_t'(z); iused_row = hb_row_t'(r);
    istart = 1'b1; iclkena = 1'b1;
    @(posedge iclk);
    n = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge iclk);
      chk(nm, model(n, nit, z, r));
      if (n == tdone + 1) begin ok = 1; break; end
      istart = 1'b0;
      iNiter = IW'($urandom); iused_zc = hb_zc_t'($urandom); iused_row = hb_row_t'($urandom);
      case (mode)
        1:       iclkena = (cyc % 2 == 1);
        2:       iclkena = ($urandom_range(0, 3) != 0);
        default: iclkena = 1'b1;
      endcase
      if (iclkena) begin
        if (oread)  nrd++;
        if (owrite) nwr++;
        if (odone && ndone < 0) ndone = n;
        n++;
      end
    end
    iclkena = 1'b1;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: reached step %0d, required %0d", nm, n, tdone + 1);
    end
  endtask

  vec_t tbl[7];
  int   rd, wr, dn;

  initial begin
    ireset = 1'b1; iclkena = 1'b1; istart = 1'b0;
    iNiter = '0; iused_zc = '0; iused_row = '0;
    #1;
    chk("reset_state", '0);
    repeat (3) @(negedge iclk);
    ireset = 1'b0;
    @(negedge iclk);
    chk("idle_after_reset", '0);

    tbl[0] = '{1, 4, 1, 0, 4, 9};
    tbl[1] = '{2, 3, 2, 0, 12, 17};
    tbl[2] = '{1, 0, 2, 0, 0, 2};
    tbl[3] = '{0, 4, 1, 0, 4, 9};
    tbl[4] = '{1, 4, 1, 1, 4, 9};
    tbl[5] = '{3, 5, 0, 0, 0, 2};
    tbl[6] = '{1, 1, 1, 2, 1, 6};
    foreach (tbl[i]) begin
      run_seq($sformatf("vec%0d", i), tbl[i].nit, tbl[i].z, tbl[i].r, tbl[i].mode, rd, wr, dn);
      chk_int($sformatf("vec%0d_reads", i), rd, tbl[i].exp_rd);
      chk_int($sformatf("vec%0d_writes", i), wr, tbl[i].exp_rd);
      chk_int($sformatf("vec%0d_done_step", i), dn, tbl[i].exp_done);
    end

    // Reset after 5 reads of a 2x3x2 run, then a clean full run.
    @(negedge iclk);
    iNiter = 6'd2; iused_zc = 9'd3; iused_row = 6'd2; istart = 1'b1;
    @(posedge iclk);
    for (int n = 1; n <= 5; n++) begin
      @(negedge iclk);
      istart = 1'b0;
      chk("pre_reset", model(n, 2, 3, 2));
    end
    ireset = 1'b1;
    #1;
    chk("async_reset", '0);
    @(negedge iclk);
    ireset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge iclk);
      chk("post_reset_quiet", '0);
    end
    run_seq("after_reset", 2, 3, 2, 0, rd, wr, dn);
    chk_int("after_reset_writes", wr, 12);

    // istart held high: back-to-back runs with one idle cycle between.
    @(negedge iclk);
    iNiter = 6'd1; iused_zc = 9'd4; iused_row = 6'd1; istart = 1'b1;
    @(posedge iclk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge iclk);
      chk("restart", model(((c - 1) % 10) + 1, 1, 4, 1));
    end
    istart = 1'b0;
    repeat (12) @(negedge iclk);
    chk("restart_settled", '0);

    // Randomized runs against the model.
    for (int i = 0; i < 8; i++) begin
      int nit, z, r, tot;
      nit = $urandom_range(0, 3); z = $urandom_range(0, 9); r = $urandom_range(0, 6);
      tot = (z == 0 || r == 0) ? 0 : ((nit == 0) ? 1 : nit) * z * r;
      run_seq($sformatf("rand%0d", i), nit, z, r, 2, rd, wr, dn);
      chk_int($sformatf("rand%0d_reads", i), rd, tot);
      chk_int($sformatf("rand%0d_writes", i), wr, tot);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
